// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: the mode select encoding,
// the FSM state encoding and small helpers that relate the two.
package led_sequencer_pkg;

    typedef enum logic [1:0] {
        ModeRotL   = 2'b00,
        ModeRotR   = 2'b01,
        ModeBounce = 2'b10,
        ModeBlink  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRotL   = 3'd1,
        StRotR   = 3'd2,
        StBncUp  = 3'd3,
        StBncDn  = 3'd4,
        StBlkOn  = 3'd5,
        StBlkOff = 3'd6
    } state_e;

    // True when the running state already belongs to the selected pattern, so a
    // tick continues the pattern instead of restarting it.
    function automatic logic in_family(state_e st, mode_e m);
        logic hit;
        hit = 1'b0;
        unique case (m)
            ModeRotL:   hit = (st == StRotL);
            ModeRotR:   hit = (st == StRotR);
            ModeBounce: hit = (st == StBncUp) || (st == StBncDn);
            ModeBlink:  hit = (st == StBlkOn) || (st == StBlkOff);
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic state_e entry_state(mode_e m);
        state_e st;
        st = StIdle;
        unique case (m)
            ModeRotL:   st = StRotL;
            ModeRotR:   st = StRotR;
            ModeBounce: st = StBncUp;
            ModeBlink:  st = StBlkOn;
            default:    st = StIdle;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Pattern-control and LED-drive bundle between the board-side controller
// (master) and the sequencer (slave).
interface led_sequencer_if
    import led_sequencer_pkg::*;
#(
    parameter int unsigned LED_COUNT = 8
);

    logic                 div_in;
    logic                 enable;
    mode_e                mode;
    logic [LED_COUNT-1:0] leds;
    logic                 step_tick;
    logic                 wrap;

    modport master (
        output div_in,
        output enable,
        output mode,
        input  leds,
        input  step_tick,
        input  wrap
    );

    modport slave (
        input  div_in,
        input  enable,
        input  mode,
        output leds,
        output step_tick,
        output wrap
    );

endinterface

// File: rtl/led_sequencer_edge_sync.sv
// Synchronizes the asynchronous divider wave and flags its rising edges with
// a combinational one-cycle rise strobe.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: each synchronized rising edge of the divider wave
// advances a rotate/bounce/blink pattern on the LED outputs.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int unsigned LED_COUNT   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    led_sequencer_if.slave  bus
);

    localparam int unsigned N = LED_COUNT;

    localparam logic [N-1:0] LedsOne = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] LedsMsb = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] LedsAll = {N{1'b1}};

    logic         rise;
    state_e       state_q;
    logic [N-1:0] leds_q;
    logic         tick_q;
    logic         wrap_q;

    logic [N-1:0] rot_l;
    logic [N-1:0] rot_r;
    logic [N-1:0] shl;
    logic [N-1:0] shr;
    logic [N-1:0] init_leds;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.div_in),
        .rise (rise)
    );

    always_comb begin
        rot_l = {leds_q[N-2:0], leds_q[N-1]};
        rot_r = {leds_q[0], leds_q[N-1:1]};
        shl   = leds_q << 1;
        shr   = leds_q >> 1;
    end

    always_comb begin
        init_leds = LedsOne;
        unique case (bus.mode)
            ModeRotL:   init_leds = LedsOne;
            ModeRotR:   init_leds = LedsMsb;
            ModeBounce: init_leds = LedsOne;
            ModeBlink:  init_leds = LedsAll;
            default:    init_leds = LedsOne;
        endcase
    end

    // All outputs are registered here; leds and wrap move only on a rise edge,
    // except that dropping enable blanks the LEDs on the very next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            leds_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q <= rise;
            if (!bus.enable) begin
                state_q <= StIdle;
                leds_q  <= '0;
                wrap_q  <= 1'b0;
            end else if (!rise) begin
                wrap_q <= 1'b0;
            end else if (!in_family(state_q, bus.mode)) begin
                // Idle or a mode switch: start the selected pattern from scratch.
                state_q <= entry_state(bus.mode);
                leds_q  <= init_leds;
                wrap_q  <= 1'b0;
            end else begin
                case (state_q)
                    StRotL: begin
                        leds_q <= rot_l;
                        wrap_q <= (leds_q == LedsMsb);
                    end
                    StRotR: begin
                        leds_q <= rot_r;
                        wrap_q <= (leds_q == LedsOne);
                    end
                    StBncUp: begin
                        leds_q <= shl;
                        wrap_q <= 1'b0;
                        if (shl == LedsMsb) begin
                            state_q <= StBncDn;
                        end
                    end
                    StBncDn: begin
                        leds_q <= shr;
                        wrap_q <= (shr == LedsOne);
                        if (shr == LedsOne) begin
                            state_q <= StBncUp;
                        end
                    end
                    StBlkOn: begin
                        state_q <= StBlkOff;
                        leds_q  <= '0;
                        wrap_q  <= 1'b0;
                    end
                    StBlkOff: begin
                        state_q <= StBlkOn;
                        leds_q  <= LedsAll;
                        wrap_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                        leds_q  <= '0;
                        wrap_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.leds      = leds_q;
    assign bus.step_tick = tick_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Consumes the slow square wave from the clock divider stage.
- Synchronizes that wave into the system clock domain and detects its rising edges to form a one-cycle step tick.
- Each step tick advances a small LED pattern state machine: rotate left, rotate right, bounce or blink.
- Sits between the divider output and the board LED pins; the divider determines step rate, this block determines pattern.

Parameters:
- LED_COUNT, 8, number of LED outputs; legal range 2..32.
- SYNC_STAGES, 2, synchronizer flop count on div_in; legal range 2..4.

Ports:
- clk, input, 1, system clock; same clock that drives the divider.
- rst_n, input, 1, asynchronous active-low reset.
- div_in, input, 1, divided square wave; treated as asynchronous, always synchronized.
- enable, input, 1, level: 1 = run pattern, 0 = LEDs dark.
- mode, input, 2, pattern select: 00 ROT_L, 01 ROT_R, 10 BOUNCE, 11 BLINK.
- leds, output, LED_COUNT, registered LED drive.
- step_tick, output, 1, registered one-cycle pulse per detected rising edge of div_in.
- wrap, output, 1, registered one-cycle pulse when the pattern completes a period.

Behaviour:
- Reset (asynchronous, rst_n low):
  - leds = 0, step_tick = 0, wrap = 0.
  - Synchronizer flops and edge-history flop = 0.
  - State = IDLE.
- Edge detect:
  - rise = sync_out & ~hist.
  - step_tick registers rise.
  - Latency: step_tick is high in the cycle SYNC_STAGES+1 clk edges after the first edge that samples div_in = 1.
  - step_tick is exactly 1 cycle wide; it pulses regardless of enable.
- After reset release with div_in already high, exactly one step_tick is produced. This is required and deterministic.
- leds and wrap update on the same clk edge that sets step_tick (registered from rise). No change on any other edge, except the enable = 0 case below.
- States: IDLE, ROT_L, ROT_R, BNC_UP, BNC_DN, BLK_ON, BLK_OFF.
- enable = 0:
  - On the next clk edge: state <- IDLE, leds <- 0, wrap <- 0.
  - Takes effect independent of rise.
- IDLE with enable = 1: on rise, load the initial pattern of mode; wrap stays 0.
  - ROT_L: leds = 1.
  - ROT_R: leds = 1 << (LED_COUNT-1).
  - BOUNCE: leds = 1, state BNC_UP.
  - BLINK: leds = all ones, state BLK_ON.
- Running, on rise, when mode matches the current state family:
  - ROT_L: rotate left. wrap = 1 when leds was MSB-only and becomes bit0.
  - ROT_R: rotate right. wrap = 1 when bit0 becomes MSB.
  - BNC_UP: shift left. On reaching MSB, state -> BNC_DN.
  - BNC_DN: shift right. On reaching bit0, state -> BNC_UP and wrap = 1.
  - BLK_ON -> BLK_OFF: leds = 0.
  - BLK_OFF -> BLK_ON: leds = all ones, wrap = 1.
- Running, on rise, when mode differs from the current family: load the new mode's initial pattern as if from IDLE; wrap = 0.
- mode is sampled only on rise; mode changes between ticks are invisible until the next tick.
- Invariant: in ROT and BNC states, leds is always one-hot.
- LED_COUNT = 2 BOUNCE: 01 -> 10 (state DN) -> 01 (wrap) -> 10.
- Reset mid-pattern: immediate clear; the pattern restarts from IDLE.

Decomposition:
- Shared defs package/header led_seq_defs:
  - Mode encodings MODE_ROT_L/ROT_R/BOUNCE/BLINK.
  - State encodings (3-bit).
  - Shared by RTL and bench.
- Sub-module edge_sync(clk, rst_n, d, rise), parameterized by SYNC_STAGES: SYNC_STAGES-flop synchronizer plus history flop, combinational rise output.
- Top instantiates edge_sync and contains the FSM and output registers.

Test Plan:
- Reset, enable = 1, mode = 00, div_in toggling every 10 clk -> first tick loads leds = 0x01. Subsequent ticks give 0x02, 0x04 ... 0x80, then 0x01 with wrap = 1 for 1 cycle. step_tick is 3 clk after each div_in rise.
- mode = 10, LED_COUNT = 8 -> leds 0x01, 0x02 ... 0x80, 0x40 ... 0x01. wrap = 1 only on the return to 0x01; the sequence repeats.
- mode = 11 -> leds 0xFF, 0x00, 0xFF (wrap = 1), 0x00 on successive ticks.
- Running ROT_L at 0x08; change mode to 01 mid-interval -> leds hold 0x08 until the next tick, then load 0x80 with wrap = 0. On the following tick leds = 0x40.
- enable dropped while leds = 0x20 -> next clk leds = 0x00, no wrap. Re-enable -> first tick loads 0x01.
- Assert rst_n low mid-pattern while div_in is high -> outputs 0 immediately. After release, exactly one step_tick within 3 clk; leds = 0x01 if enable = 1 and mode = 00.
